// File: rtl/team10_wb_stream_bridge.sv
// team10_wb_stream_bridge
//
// Wishbone slave register bank that bridges single-beat bus accesses into a
// TX byte stream toward the core and an RX byte stream back from it. Each
// direction is buffered in a DEPTH-entry FIFO. A 3-bit IRQ vector is driven
// from the FIFO status.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   adr_i, dat_i, sel_i  Wishbone address, write data, byte lane selects
//   cyc_i, stb_i, we_i   Wishbone cycle, strobe, write enable
//   dat_o, ack_o         Wishbone read data (0 outside ack), acknowledge
//   IRQ                  masked interrupt vector (registered)
//   tx_data/valid/ready  TX stream toward the core
//   rx_data/valid/ready  RX stream from the core
//
// Register map (word offset adr_i[4:2]):
//   0 CTRL      [0] enable, [1] tx_flush, [2] rx_flush (flush bits self-clear)
//   1 STATUS    [7:0] tx_count, [15:8] rx_count, [16] tx_full, [17] rx_empty
//   2 TXDATA    write pushes TX FIFO; push into full FIFO sets tx_overflow
//   3 RXDATA    read pops RX FIFO head (0 when empty)
//   4 IRQ_EN    [2:0]
//   5 IRQ_STAT  [0] rx_nonempty, [1] tx_empty, [2] tx_overflow (W1C)
//   6,7         reserved, acked, read 0
module team10_wb_stream_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DW        = 8,
    parameter int unsigned DEPTH     = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   adr_i,
    input  logic [31:0]   dat_i,
    output logic [31:0]   dat_o,
    input  logic [3:0]    sel_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    output logic          ack_o,
    output logic [2:0]    IRQ,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [2:0]    irq_q, irq_d;
    logic          en_q, en_d;
    logic [2:0]    irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] tx_mem_q [DEPTH];
    logic [DW-1:0] tx_mem_d [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic [DW-1:0] rx_mem_q [DEPTH];
    logic [DW-1:0] rx_mem_d [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;

    logic          req, wr, rd;
    logic [2:0]    off;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_wr_req, tx_push, tx_pop, tx_flush;
    logic          rx_push, rx_pop, rx_flush;
    logic [2:0]    irq_stat;
    logic [31:0]   status, rx_word;
    logic          unused_bits;

    assign ack_o    = ack_q;
    assign dat_o    = dat_q;
    assign IRQ      = irq_q;
    assign tx_data  = tx_mem_q[tx_rptr_q];

    always_comb begin
        req       = stb_i & cyc_i & ~ack_q & (adr_i[31:8] == BASE_ADDR[31:8]);
        wr        = req & we_i;
        rd        = req & ~we_i;
        off       = adr_i[4:2];

        tx_full   = (tx_cnt_q == FULL_CNT);
        tx_empty  = (tx_cnt_q == '0);
        rx_full   = (rx_cnt_q == FULL_CNT);
        rx_empty  = (rx_cnt_q == '0);
        tx_valid  = en_q & ~tx_empty;
        rx_ready  = en_q & ~rx_full;

        // Fullness is judged on pre-edge state, so a concurrent core pop
        // does not rescue a bus push into a full TX FIFO.
        tx_wr_req = wr & (off == 3'd2) & (|sel_i);
        tx_push   = tx_wr_req & ~tx_full;
        tx_pop    = tx_valid & tx_ready;
        tx_flush  = wr & (off == 3'd0) & sel_i[0] & dat_i[1];
        rx_push   = rx_valid & rx_ready;
        rx_pop    = rd & (off == 3'd3) & ~rx_empty;
        rx_flush  = wr & (off == 3'd0) & sel_i[0] & dat_i[2];

        irq_stat  = {ovf_q, tx_empty, ~rx_empty};

        status             = '0;
        status[AW:0]       = tx_cnt_q;
        status[8 +: AW+1]  = rx_cnt_q;
        status[16]         = tx_full;
        status[17]         = rx_empty;

        rx_word            = '0;
        rx_word[DW-1:0]    = rx_mem_q[rx_rptr_q];

        unused_bits = ^{adr_i[7:5], adr_i[1:0], dat_i};
    end

    // Bus side: ack, read data, control registers.
    always_comb begin
        ack_d    = req;
        dat_d    = '0;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        irq_d    = irq_stat & irq_en_q;

        if (rd) begin
            case (off)
                3'd0:    dat_d = {31'b0, en_q};
                3'd1:    dat_d = status;
                3'd3:    dat_d = rx_empty ? '0 : rx_word;
                3'd4:    dat_d = {29'b0, irq_en_q};
                3'd5:    dat_d = {29'b0, irq_stat};
                default: dat_d = '0;
            endcase
        end

        if (wr && sel_i[0]) begin
            case (off)
                3'd0:    en_d     = dat_i[0];
                3'd4:    irq_en_d = dat_i[2:0];
                3'd5:    if (dat_i[2]) ovf_d = 1'b0;
                default: ;
            endcase
        end
        if (tx_wr_req && tx_full) ovf_d = 1'b1;
    end

    // FIFO next state; flush overrides push and pop in the same cycle.
    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;

        if (tx_push) tx_mem_d[tx_wptr_q] = dat_i[DW-1:0];
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
            tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        end

        if (rx_push) rx_mem_d[rx_wptr_q] = rx_data;
        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
            rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= '0;
            ovf_q     <= 1'b0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_mem_q  <= tx_mem_d;
            rx_mem_q  <= rx_mem_d;
        end
    end

endmodule

// File: tb/tb_team10_wb_stream_bridge.sv
// Directed testbench for team10_wb_stream_bridge (default parameters).
module tb_team10_wb_stream_bridge;
    localparam logic [31:0] A_CTRL  = 32'h3000_0000;
    localparam logic [31:0] A_STAT  = 32'h3000_0004;
    localparam logic [31:0] A_TX    = 32'h3000_0008;
    localparam logic [31:0] A_RX    = 32'h3000_000C;
    localparam logic [31:0] A_IEN   = 32'h3000_0010;
    localparam logic [31:0] A_ISTAT = 32'h3000_0014;
    localparam logic [31:0] A_RSV   = 32'h3000_0018;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic        ack_o;
    logic [2:0]  IRQ;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] rdata;
    int          ncyc;

    team10_wb_stream_bridge #(
        .BASE_ADDR(32'h3000_0000),
        .DW(8),
        .DEPTH(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o),
        .IRQ(IRQ), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Single bus transfer; called #1 after a clock edge, returns #1 after the ack edge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int cycles);
        logic got_ack;
        got_ack = 1'b0;
        rd      = '0;
        cycles  = 0;
        adr_i = adr; dat_i = dat; sel_i = sel; we_i = we; cyc_i = 1'b1; stb_i = 1'b1;
        for (int i = 0; i < 4 && !got_ack; i++) begin
            @(posedge clk_i); #1;
            cycles++;
            if (ack_o) begin
                got_ack = 1'b1;
                rd      = dat_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (!got_ack) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        int          c;
        wb_xfer(1'b1, adr, dat, sel, d, c);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
        int c;
        wb_xfer(1'b0, adr, '0, 4'hF, d, c);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_ack", {31'b0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {29'b0, IRQ}, 32'd0);
        chk("rst_txv", {31'b0, tx_valid}, 32'd0);
        chk("rst_rxr", {31'b0, rx_ready}, 32'd0);

        wb_xfer(1'b0, A_STAT, '0, 4'hF, rdata, ncyc);
        chk("rst_status", rdata, 32'h0002_0000);
        chk("ack_latency", ncyc, 32'd1);
        wb_rd(A_ISTAT, rdata);
        chk("rst_istat", rdata, 32'h2);
        wb_rd(A_RSV, rdata);
        chk("rsv_read", rdata, 32'h0);

        // Non-hit address gets no ack
        adr_i = 32'h4000_0008; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 chk("miss_noack", {31'b0, ack_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;

        // TX basic: hold then drain
        wb_wr(A_CTRL, 32'h1, 4'hF);
        chk("en_rxready", {31'b0, rx_ready}, 32'd1);
        wb_wr(A_TX, 32'hA1, 4'h1);
        wb_wr(A_TX, 32'hB2, 4'h1);
        chk("tx_valid_held", {31'b0, tx_valid}, 32'd1);
        chk("tx_head", {24'b0, tx_data}, 32'hA1);
        repeat (2) @(posedge clk_i);
        #1 chk("tx_head_stable", {24'b0, tx_data}, 32'hA1);
        wb_rd(A_STAT, rdata);
        chk("status_tx2", rdata, 32'h0002_0002);
        tx_ready = 1'b1;
        chk("tx_pop0", {24'b0, tx_data}, 32'hA1);
        @(posedge clk_i); #1;
        chk("tx_pop1", {24'b0, tx_data}, 32'hB2);
        chk("tx_valid1", {31'b0, tx_valid}, 32'd1);
        @(posedge clk_i); #1;
        chk("tx_drained", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        wb_rd(A_STAT, rdata);
        chk("status_tx0", rdata, 32'h0002_0000);

        // TX overflow
        wb_wr(A_IEN, 32'h4, 4'h1);
        for (int i = 0; i < 9; i++) wb_wr(A_TX, 32'h10 + i, 4'h1);
        wb_rd(A_STAT, rdata);
        chk("status_txfull", rdata, 32'h0003_0008);
        chk("irq_ovf", {29'b0, IRQ}, 32'h4);
        wb_rd(A_ISTAT, rdata);
        chk("istat_ovf", rdata, 32'h4);
        wb_wr(A_ISTAT, 32'h4, 4'h1);
        wb_rd(A_STAT, rdata);
        chk("status_after_w1c", rdata, 32'h0003_0008);
        chk("irq_cleared", {29'b0, IRQ}, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain_data", {24'b0, tx_data}, 32'h10 + i);
            @(posedge clk_i); #1;
        end
        chk("tx_drain_done", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // RX basic + IRQ_EN byte lanes
        wb_wr(A_IEN, 32'h1, 4'h1);
        wb_wr(A_IEN, 32'h7, 4'hE);
        wb_rd(A_IEN, rdata);
        chk("ien_bytelane", rdata, 32'h1);
        rx_valid = 1'b1; rx_data = 8'h11;
        @(posedge clk_i); #1 rx_data = 8'h22;
        @(posedge clk_i); #1 rx_data = 8'h33;
        @(posedge clk_i); #1 rx_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 chk("irq_rx", {29'b0, IRQ}, 32'h1);
        wb_rd(A_RX, rdata); chk("rx_rd0", rdata, 32'h11);
        wb_rd(A_RX, rdata); chk("rx_rd1", rdata, 32'h22);
        wb_rd(A_RX, rdata); chk("rx_rd2", rdata, 32'h33);
        wb_rd(A_RX, rdata); chk("rx_rd_empty", rdata, 32'h0);
        wb_rd(A_STAT, rdata);
        chk("status_rx0", rdata, 32'h0002_0000);
        chk("irq_rx_gone", {29'b0, IRQ}, 32'h0);

        // RX full backpressure
        rx_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rx_data = 8'h40 + k;
            @(posedge clk_i); #1;
        end
        rx_data = 8'h48;
        chk("rx_full_ready", {31'b0, rx_ready}, 32'd0);
        wb_rd(A_STAT, rdata);
        chk("status_rxfull", rdata, 32'h0000_0800);
        wb_rd(A_RX, rdata);
        chk("rx_full_pop", rdata, 32'h40);
        chk("rx_ready_back", {31'b0, rx_ready}, 32'd1);
        @(posedge clk_i); #1 rx_valid = 1'b0;
        chk("rx_refull", {31'b0, rx_ready}, 32'd0);
        for (int k = 1; k < 9; k++) begin
            wb_rd(A_RX, rdata);
            chk("rx_full_data", rdata, 32'h40 + k);
        end

        // Flush both FIFOs
        wb_wr(A_TX, 32'h55, 4'h1);
        wb_wr(A_TX, 32'h66, 4'h1);
        rx_valid = 1'b1; rx_data = 8'h77;
        repeat (3) @(posedge clk_i);
        #1 rx_valid = 1'b0;
        wb_rd(A_STAT, rdata);
        chk("status_prefl", rdata, 32'h0000_0302);
        wb_wr(A_CTRL, 32'h7, 4'h1);
        chk("flush_txv", {31'b0, tx_valid}, 32'd0);
        wb_rd(A_STAT, rdata);
        chk("status_flushed", rdata, 32'h0002_0000);
        wb_rd(A_CTRL, rdata);
        chk("ctrl_readback", rdata, 32'h1);
        wb_rd(A_ISTAT, rdata);
        chk("istat_flush", rdata, 32'h2);

        // Enable stalls streams, bus still works
        wb_wr(A_CTRL, 32'h0, 4'h1);
        tx_ready = 1'b1;
        wb_wr(A_TX, 32'h5A, 4'h1);
        chk("dis_txv", {31'b0, tx_valid}, 32'd0);
        chk("dis_rxr", {31'b0, rx_ready}, 32'd0);
        wb_rd(A_STAT, rdata);
        chk("dis_status", rdata, 32'h0002_0001);
        tx_ready = 1'b0;
        wb_wr(A_CTRL, 32'h1, 4'h1);
        chk("reen_txv", {31'b0, tx_valid}, 32'd1);
        chk("reen_txd", {24'b0, tx_data}, 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
